pwm_duty_selector: RTL and testbench

- Parametrised, registered N-channel duty-cycle selector for the PWM/LED dimmer path.
- Selects one of CHANNELS packed duty words and presents it to the PWM comparator.
- Selection can be manual (sel input) or an automatic scan with a per-channel dwell time.
- Output changes only on PWM period boundaries, so duty changes never glitch mid-period.

---
 rtl/pwm_duty_selector.sv | 108 ++++++++++
 tb/tb_pwm_duty_selector.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pwm_duty_selector.sv
// Registered N-channel duty selector for the PWM dimmer; updates only on PWM period boundaries.
// Optional macro MUX_FADE_EN: output slews toward the selected duty by at most FADE_STEP per period.
module pwm_duty_selector #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned DWELL     = 100,
    parameter int unsigned FADE_STEP = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      auto_en,
    input  logic                      period_end,
    output logic [WIDTH-1:0]          duty_out,
    output logic [SEL_W-1:0]          cur_ch,
    output logic                      switched
);

    localparam int unsigned CNT_W = $clog2(DWELL) + 1;

    // Reject configurations the datapath cannot represent.
    generate
        if (CHANNELS < 2 || CHANNELS > 16 || SEL_W != $clog2(CHANNELS) ||
            DWELL < 1 || DWELL > 65535 || FADE_STEP < 1) begin : g_bad_param
            $error("pwm_duty_selector: illegal parameter combination");
        end
    endgenerate

    logic [WIDTH-1:0] duty_q,   duty_d;
    logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             switched_q, switched_d;
    logic [WIDTH-1:0] target;

    function automatic logic [WIDTH-1:0] slice_of(input logic [SEL_W-1:0]          ch,
                                                  input logic [CHANNELS*WIDTH-1:0] d);
        logic [WIDTH-1:0] s;
        s = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (ch == SEL_W'(k)) s = d[k*WIDTH +: WIDTH];
        end
        return s;
    endfunction

`ifdef MUX_FADE_EN
    logic [31:0] tgt_w, cur_w;
`endif

    // Next-state: everything advances only on a period_end strobe.
    always_comb begin
        cur_ch_d = cur_ch_q;
        cnt_d    = cnt_q;
        duty_d   = duty_q;
        target   = '0;
`ifdef MUX_FADE_EN
        tgt_w    = '0;
        cur_w    = '0;
`endif
        if (period_end) begin
            if (auto_en) begin
                if (cnt_q == CNT_W'(DWELL - 1)) begin
                    cnt_d    = '0;
                    cur_ch_d = (cur_ch_q == SEL_W'(CHANNELS - 1)) ? '0 : cur_ch_q + SEL_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
                if (32'(sel) < CHANNELS) cur_ch_d = sel;
            end
            target = slice_of(cur_ch_d, data_in);
`ifdef MUX_FADE_EN
            // Slew toward target; the step never passes it, so no wrap is possible.
            tgt_w = 32'(target);
            cur_w = 32'(duty_q);
            if (tgt_w > cur_w) begin
                duty_d = (tgt_w - cur_w <= FADE_STEP) ? target : WIDTH'(cur_w + FADE_STEP);
            end else begin
                duty_d = (cur_w - tgt_w <= FADE_STEP) ? target : WIDTH'(cur_w - FADE_STEP);
            end
`else
            duty_d = target;
`endif
        end
        switched_d = period_end && (cur_ch_d != cur_ch_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_q     <= '0;
            cur_ch_q   <= '0;
            cnt_q      <= '0;
            switched_q <= 1'b0;
        end else begin
            duty_q     <= duty_d;
            cur_ch_q   <= cur_ch_d;
            cnt_q      <= cnt_d;
            switched_q <= switched_d;
        end
    end

    assign duty_out = duty_q;
    assign cur_ch   = cur_ch_q;
    assign switched = switched_q;

endmodule

// File: tb/tb_pwm_duty_selector.sv
// Directed bench for pwm_duty_selector: manual, boundary hold, auto scan, mode switch, reset, fade.
module tb_pwm_duty_selector;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned CHANNELS = 4;
    localparam int unsigned SEL_W    = 2;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]          sel;
    logic                      auto_en;
    logic                      period_end;
    logic [WIDTH-1:0]          duty_out;
    logic [SEL_W-1:0]          cur_ch;
    logic                      switched;

    int n_checks = 0;
    int n_errors = 0;
    int n_switch = 0;
    int exp_ch;
    int duty_tab [4] = '{8, 4, 2, 1};
    int fade_tab [4];

    pwm_duty_selector #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .DWELL(3), .FADE_STEP(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .sel(sel), .auto_en(auto_en),
        .period_end(period_end), .duty_out(duty_out), .cur_ch(cur_ch), .switched(switched)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One-cycle period_end; returns on the negedge after the sampling edge.
    task automatic strobe();
        period_end = 1'b1;
        @(negedge clk);
        period_end = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_out(input string tag, input int d, input int c, input int s);
        check({tag, ".duty"}, 32'(duty_out), 32'(d));
        check({tag, ".ch"},   32'(cur_ch),   32'(c));
        check({tag, ".sw"},   32'(switched), 32'(s));
    endtask

    initial begin
        reset_n    = 1'b0;
        data_in    = {4'd1, 4'd2, 4'd4, 4'd8};
        sel        = '0;
        auto_en    = 1'b0;
        period_end = 1'b0;
        idle(3);
        check_out("reset", 0, 0, 0);
        reset_n = 1'b1;
        idle(2);
        check_out("post_release", 0, 0, 0);

        // Manual selection of every channel
        sel = 2'd0; strobe(); check_out("man0", 8, 0, 0);
        sel = 2'd1; strobe(); check_out("man1", 4, 1, 1);
        idle(1);    check("man1.sw_drop", 32'(switched), 32'd0);
        sel = 2'd2; strobe(); check_out("man2", 2, 2, 1);
        sel = 2'd3; strobe(); check_out("man3", 1, 3, 1);
        sel = 2'd0; idle(3);  check_out("sel_nostrobe", 1, 3, 0);

        // Data change on the active channel only lands at a period boundary
        sel = 2'd1; strobe(); check_out("hold_a", 4, 1, 1);
        data_in = {4'd1, 4'd2, 4'd9, 4'd8};
        idle(2);    check("hold_b.duty", 32'(duty_out), 32'd4);
        strobe();   check_out("hold_c", 9, 1, 0);
        data_in = {4'd1, 4'd2, 4'd4, 4'd8};
        strobe();   check("hold_d.duty", 32'(duty_out), 32'd4);

        // Auto scan with DWELL=3 from ch0; sel is ignored
        sel = 2'd0; strobe(); check_out("pre_auto", 8, 0, 1);
        auto_en = 1'b1;
        sel     = 2'd3;
        for (int i = 1; i <= 13; i++) begin
            exp_ch = (i < 3) ? 0 : (i < 6) ? 1 : (i < 9) ? 2 : (i < 12) ? 3 : 0;
            strobe();
            if (switched) n_switch++;
            check($sformatf("auto%0d.ch", i), 32'(cur_ch), 32'(exp_ch));
            check($sformatf("auto%0d.duty", i), 32'(duty_out), 32'(duty_tab[exp_ch]));
            check($sformatf("auto%0d.sw", i), 32'(switched),
                  32'((i == 3 || i == 6 || i == 9 || i == 12) ? 1 : 0));
        end
        check("auto.switch_count", 32'(n_switch), 32'd4);

        // Enter auto from ch2 with a fresh dwell count, then drop back to manual
        auto_en = 1'b0; sel = 2'd2; strobe(); check_out("ms_man2", 2, 2, 1);
        auto_en = 1'b1;
        strobe(); check_out("ms_a1", 2, 2, 0);
        strobe(); check_out("ms_a2", 2, 2, 0);
        strobe(); check_out("ms_a3", 1, 3, 1);
        auto_en = 1'b0; sel = 2'd0;
        idle(2);  check_out("ms_wait", 1, 3, 0);
        strobe(); check_out("ms_man0", 8, 0, 1);

        // Asynchronous reset mid-cycle, away from any clock edge
        sel = 2'd2; strobe(); check_out("pre_rst", 2, 2, 1);
        #2 reset_n = 1'b0;
        #1 check_out("async_rst", 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);

        // Fade from ch3 (1) to ch0 (8)
`ifdef MUX_FADE_EN
        fade_tab = '{4, 7, 8, 8};
`else
        fade_tab = '{8, 8, 8, 8};
`endif
        sel = 2'd3; strobe(); check_out("fade_ch3", 1, 3, 1);
        sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            strobe();
            check_out($sformatf("fade%0d", i), fade_tab[i], 0, (i == 0) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
